mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single graph-memory port between up to NUM_REQ requesters: edge cache, distance table, visited-set and host loader.
- Replaces ad-hoc tri-state release of mem_addr/mem_read_enable; the memory side is always actively driven.
- Round-robin grant, one outstanding transaction at a time, read and write support, and a watchdog timeout so a dead memory cannot hang the scheduler.

Parameters:
- NUM_REQ, 4, number of requester ports
- REQ_IDX_WIDTH, 2, clog2(NUM_REQ)
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width
- TIMEOUT_CYCLES, 255, BUSY cycles allowed before abort; 0 disables the watchdog
- TIMEOUT_WIDTH, 8, watchdog counter width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request, level
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*MADDR_WIDTH  flattened; slice k = requester k
- req_wdata  in  NUM_REQ*MDATA_WIDTH  flattened write data
- grant  out  NUM_REQ  one-hot owner during BUSY/RESP
- resp_valid  out  NUM_REQ  one-cycle completion pulse to owner
- resp_error  out  1  qualifies resp_valid; 1 = timed out
- resp_data  out  MDATA_WIDTH  read data, valid with resp_valid
- mem_addr  out  MADDR_WIDTH  memory address
- mem_wdata  out  MDATA_WIDTH  memory write data
- mem_read_enable  out  1  read strobe, level
- mem_write_enable  out  1  write strobe, level
- mem_data  in  MDATA_WIDTH  memory read data
- mem_ready  in  1  memory ack for read or write

Behaviour:
- All outputs are registered.
- On reset (async): state=IDLE, rr_ptr=0, every output is 0 (never z), watchdog=0.
- States: IDLE, BUSY, RESP.
- IDLE: if any req_valid, pick the first set bit searching rr_ptr, rr_ptr+1, … mod NUM_REQ. Latch its addr/wdata/write and g.
  - On that edge: grant=onehot(g), mem_addr/mem_wdata driven, mem_read_enable=!write, mem_write_enable=write, watchdog=0, go to BUSY.
  - If no req_valid: stay in IDLE, outputs 0.
- BUSY: enables and mem_addr held constant; watchdog +1 per cycle.
  - mem_ready=1 sampled: enables->0, resp_data<=mem_data (read) or 0 (write), resp_valid[g]=1, resp_error=0, go to RESP.
  - Else if TIMEOUT_CYCLES!=0 and watchdog==TIMEOUT_CYCLES-1: enables->0, resp_data=0, resp_valid[g]=1, resp_error=1, go to RESP.
  - mem_ready and timeout on the same edge: mem_ready wins (resp_error=0).
- RESP: lasts exactly one cycle. resp_valid/resp_error/resp_data are visible. Next edge: resp_valid=0, resp_error=0, grant=0, rr_ptr=(g+1) mod NUM_REQ, go to IDLE.
- Latency with req in IDLE at edge E0 and mem_ready already high:
  - BUSY from E0
  - mem_ready sampled at E1
  - resp_valid high E1..E2
  - back to IDLE at E2
  - next grant at E3 at the earliest
- Requesters hold req_valid/req_* until resp_valid.
  - If a requester drops req_valid mid-BUSY, the transaction still completes and the response is still pulsed.
  - req_* changes after grant are ignored (values are latched).
- mem_ready outside BUSY is ignored.
- Reset mid-BUSY aborts immediately: no response pulse, enables low asynchronously.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,3,0,…
- No starvation: each requester waits at most NUM_REQ-1 transactions.
- rr_ptr wraps from NUM_REQ-1 to 0. Address width is passed through; the arbiter does no arithmetic on addresses.

Decomposition:
- constants.v gains:
  - `ARB_IDLE/`ARB_BUSY/`ARB_RESP state encodings (2 bits)
  - `DEFAULT_NUM_REQ=4
  - `DEFAULT_TIMEOUT_CYCLES=255
- One natural sub-module: rr_priority_picker. It is combinational: req vector + rr_ptr -> found flag + index, with rotate and priority-encode. It is reusable by the scheduler's node-select logic.

Test Plan:
- Single read: req_valid=4'b0010, addr1=0x40; memory returns 0x1234 with mem_ready two BUSY cycles later -> mem_read_enable high for 3 cycles with mem_addr=0x40; resp_valid=4'b0010 for 1 cycle; resp_data=0x1234; resp_error=0.
- Contention: req_valid=4'b1011 held, rr_ptr=0, memory acks in 1 cycle -> grant sequence 0001, 0010, 1000, 0001; each response is pulsed only to its owner.
- Write: req 2, write=1, addr=0x80, wdata=0xBEEF -> mem_write_enable=1, mem_read_enable=0, mem_wdata=0xBEEF; after mem_ready, resp_valid[2]=1 and resp_data=0.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> enables drop after 4 BUSY cycles; resp_valid pulsed with resp_error=1; next requester is granted afterwards.
- Reset in BUSY: assert reset between clock edges during a read -> all outputs 0 immediately, no resp_valid. After release, a pending req_valid[3] is granted first (rr_ptr=0 and requesters 0–2 idle).
- Race: mem_ready rises on the same edge the watchdog expires -> resp_error=0 and resp_data=mem_data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the graph-memory arbiter and its round-robin picker.
package mem_arbiter_pkg;

  localparam int unsigned DEFAULT_NUM_REQ        = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
  localparam int unsigned DEFAULT_MADDR_WIDTH    = 16;
  localparam int unsigned DEFAULT_MDATA_WIDTH    = 16;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbBusy = 2'd1,
    ArbResp = 2'd2
  } arb_state_e;

  // Wraps a requester index into 0..n-1; n need not be a power of two.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return v % n;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request bit at or after i_ptr, wrapping.
module mem_arbiter_rr_priority_picker
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEFAULT_NUM_REQ,
  parameter int unsigned IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [IDX_WIDTH-1:0] i_ptr,
  output logic                 o_found,
  output logic [IDX_WIDTH-1:0] o_idx
);

  logic [IDX_WIDTH-1:0] w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = IDX_WIDTH'(rr_wrap(32'(i_ptr) + i, NUM_REQ));
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single graph-memory port: one outstanding read/write at a
// time, registered outputs, and a watchdog that aborts a transaction the memory never acks.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int unsigned REQ_IDX_WIDTH  = 2,
  parameter int unsigned MADDR_WIDTH    = DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH    = DEFAULT_MDATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*MADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*MDATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic                           resp_error,
  output logic [MDATA_WIDTH-1:0]         resp_data,
  output logic [MADDR_WIDTH-1:0]         mem_addr,
  output logic [MDATA_WIDTH-1:0]         mem_wdata,
  output logic                           mem_read_enable,
  output logic                           mem_write_enable,
  input  logic [MDATA_WIDTH-1:0]         mem_data,
  input  logic                           mem_ready
);

  localparam bit                       WdogEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] WdogLast = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_e               r_state;
  logic [REQ_IDX_WIDTH-1:0] r_rr_ptr;
  logic [REQ_IDX_WIDTH-1:0] r_owner;
  logic [TIMEOUT_WIDTH-1:0] r_wdog;
  logic [NUM_REQ-1:0]       r_grant;
  logic [NUM_REQ-1:0]       r_resp_valid;
  logic                     r_resp_error;
  logic [MDATA_WIDTH-1:0]   r_resp_data;
  logic [MADDR_WIDTH-1:0]   r_mem_addr;
  logic [MDATA_WIDTH-1:0]   r_mem_wdata;
  logic                     r_mem_re;
  logic                     r_mem_we;

  logic                     w_found;
  logic [REQ_IDX_WIDTH-1:0] w_idx;
  logic                     w_timeout;

  mem_arbiter_rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_timeout = WdogEn && (r_wdog == WdogLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ArbIdle;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_wdog       <= '0;
      r_grant      <= '0;
      r_resp_valid <= '0;
      r_resp_error <= 1'b0;
      r_resp_data  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      unique case (r_state)
        ArbIdle: begin
          if (w_found) begin
            r_owner     <= w_idx;
            r_grant     <= NUM_REQ'(1) << w_idx;
            r_mem_addr  <= req_addr[w_idx*MADDR_WIDTH +: MADDR_WIDTH];
            r_mem_wdata <= req_wdata[w_idx*MDATA_WIDTH +: MDATA_WIDTH];
            r_mem_re    <= !req_write[w_idx];
            r_mem_we    <= req_write[w_idx];
            r_wdog      <= '0;
            r_state     <= ArbBusy;
          end
        end
        ArbBusy: begin
          r_wdog <= r_wdog + TIMEOUT_WIDTH'(1);
          // A real ack beats a watchdog expiry landing on the same edge.
          if (mem_ready) begin
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_data  <= r_mem_re ? mem_data : '0;
            r_resp_valid <= r_grant;
            r_resp_error <= 1'b0;
            r_state      <= ArbResp;
          end else if (w_timeout) begin
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_resp_data  <= '0;
            r_resp_valid <= r_grant;
            r_resp_error <= 1'b1;
            r_state      <= ArbResp;
          end
        end
        ArbResp: begin
          r_resp_valid <= '0;
          r_resp_error <= 1'b0;
          r_resp_data  <= '0;
          r_grant      <= '0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_wdog       <= '0;
          r_rr_ptr     <= REQ_IDX_WIDTH'(rr_wrap(32'(r_owner) + 32'd1, NUM_REQ));
          r_state      <= ArbIdle;
        end
        default: r_state <= ArbIdle;
      endcase
    end
  end

  assign grant            = r_grant;
  assign resp_valid       = r_resp_valid;
  assign resp_error       = r_resp_error;
  assign resp_data        = r_resp_data;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign mem_read_enable  = r_mem_re;
  assign mem_write_enable = r_mem_we;

endmodule
